// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the Master CPU control path:
//   - control opcodes (LDR/STR/B/HLT); opcodes below OP_LDR are ALU operations
//   - ARM-style condition codes
//   - bit positions of N/Z/C/V inside the 4-bit flag word
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_LDR = 4'hC;
    localparam logic [3:0] OP_STR = 4'hD;
    localparam logic [3:0] OP_B   = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Everything below the first control opcode goes through the ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op < OP_LDR;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
// Bus between the sequencer and the rest of the core.
//   master (sequencer): drives instruction RAM enable/address, Instr, Pc,
//                       Flag, ALU enable, register write strobe, data RAM
//                       enable/direction; receives Ins_Data and New_Flag.
//   slave  (core side): the mirror image.
// -----------------------------------------------------------------------------
interface cpu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            Ins_Enable;
    logic [PC_W-1:0] Ins_Addr;
    logic [31:0]     Ins_Data;
    logic [31:0]     Instr;
    logic [PC_W-1:0] Pc;
    logic [3:0]      New_Flag;
    logic [3:0]      Flag;
    logic            Alu_Enable;
    logic            Reg_WE;
    logic            Mem_Enable;
    logic            Mem_RW;

    modport master (
        output Ins_Enable, Ins_Addr, Instr, Pc, Flag,
               Alu_Enable, Reg_WE, Mem_Enable, Mem_RW,
        input  Ins_Data, New_Flag
    );

    modport slave (
        input  Ins_Enable, Ins_Addr, Instr, Pc, Flag,
               Alu_Enable, Reg_WE, Mem_Enable, Mem_RW,
        output Ins_Data, New_Flag
    );
endinterface

// File: rtl/cpu_sequencer_cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Combinational ARM-style condition evaluator.
//   cond : 4-bit condition field of the instruction
//   flag : {N,Z,C,V}
//   pass : 1 when the instruction should execute
// -----------------------------------------------------------------------------
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flag,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flag[FLG_N];
    assign z = flag[FLG_Z];
    assign c = flag[FLG_C];
    assign v = flag[FLG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // NV
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer: owns Pc, Instr, the NZCV flag register and
// the FETCH/DECODE/EXECUTE/MEM/WB state machine, plus a retired counter.
//   Clk, Reset      : clock, synchronous active-high reset
//   Run             : start pulse, only looked at in IDLE
//   bus (master)    : instruction/data RAM control, Instr, Pc, Flag, strobes
//   Halted          : core stopped by HLT (leaves only through Reset)
//   Retired_Count   : instructions retired since reset (wraps)
// All outputs come straight from flops; the strobes are computed from the
// next state so they line up with the state they belong to.
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    cpu_sequencer_if.master  bus,
    output logic             Halted,
    output logic [CNT_W-1:0] Retired_Count
);
    // Shared FETCH/MEM wait counter; RAM_LAT is at most 4, so 2 bits suffice.
    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_t            state_q,    state_d;
    logic [PC_W-1:0]   pc_q,       pc_d;
    logic [31:0]       instr_q,    instr_d;
    logic [3:0]        flag_q,     flag_d;
    logic [CNT_W-1:0]  ret_q,      ret_d;
    logic [1:0]        lat_q,      lat_d;
    logic              ins_en_q,   ins_en_d;
    logic              alu_en_q,   alu_en_d;
    logic              reg_we_q,   reg_we_d;
    logic              mem_en_q,   mem_en_d;
    logic              mem_rw_q,   mem_rw_d;
    logic              halted_q,   halted_d;

    logic [3:0]        opcode;
    logic              s_bit;
    logic [PC_W-1:0]   target;
    logic              cond_pass;

    assign opcode = instr_q[27:24];
    assign s_bit  = instr_q[23];
    assign target = instr_q[3 +: PC_W];

    cond_check u_cond_check (
        .cond (instr_q[31:28]),
        .flag (flag_q),
        .pass (cond_pass)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flag_d  = flag_q;
        ret_d   = ret_q;
        lat_d   = lat_q;

        case (state_q)
            ST_IDLE: begin
                lat_d = 2'd0;
                if (Run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    instr_d = bus.Ins_Data;
                    lat_d   = 2'd0;
                    state_d = ST_DECODE;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_DECODE: begin
                if (cond_pass) begin
                    state_d = ST_EXECUTE;
                end else begin
                    // Skipped instructions are neither retired nor written.
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                if (is_alu_op(opcode)) begin
                    if (s_bit) begin
                        flag_d = bus.New_Flag;
                    end
                    state_d = ST_WB;
                end else begin
                    case (opcode)
                        OP_LDR, OP_STR: begin
                            lat_d   = 2'd0;
                            state_d = ST_MEM;
                        end
                        OP_B: begin
                            pc_d    = target;
                            ret_d   = ret_q + CNT_W'(1);
                            state_d = ST_FETCH;
                        end
                        default: begin  // HLT
                            ret_d   = ret_q + CNT_W'(1);
                            state_d = ST_HALT;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = 2'd0;
                    state_d = ST_WB;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_WB: begin
                pc_d    = pc_q + PC_W'(1);
                ret_d   = ret_q + CNT_W'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered strobes, decoded from the state being entered.
        ins_en_d = (state_d == ST_FETCH);
        alu_en_d = (state_d == ST_EXECUTE) || (state_d == ST_MEM) || (state_d == ST_WB);
        mem_en_d = (state_d == ST_MEM);
        mem_rw_d = !((state_d == ST_MEM) && (opcode == OP_STR));
        reg_we_d = (state_d == ST_WB) && (opcode != OP_STR);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            flag_q   <= 4'b0000;
            ret_q    <= '0;
            lat_q    <= 2'd0;
            ins_en_q <= 1'b0;
            alu_en_q <= 1'b0;
            reg_we_q <= 1'b0;
            mem_en_q <= 1'b0;
            mem_rw_q <= 1'b1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            flag_q   <= flag_d;
            ret_q    <= ret_d;
            lat_q    <= lat_d;
            ins_en_q <= ins_en_d;
            alu_en_q <= alu_en_d;
            reg_we_q <= reg_we_d;
            mem_en_q <= mem_en_d;
            mem_rw_q <= mem_rw_d;
            halted_q <= halted_d;
        end
    end

    assign bus.Ins_Enable = ins_en_q;
    assign bus.Ins_Addr   = pc_q;
    assign bus.Pc         = pc_q;
    assign bus.Instr      = instr_q;
    assign bus.Flag       = flag_q;
    assign bus.Alu_Enable = alu_en_q;
    assign bus.Reg_WE     = reg_we_q;
    assign bus.Mem_Enable = mem_en_q;
    assign bus.Mem_RW     = mem_rw_q;
    assign Halted         = halted_q;
    assign Retired_Count  = ret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Two sequencers: A (PC_W=8, RAM_LAT=1) runs conditional ALU ops, a branch
// and HLT; B (PC_W=4, RAM_LAT=3) runs LDR/STR, a branch to the top address
// with Pc wrap, and a reset in the middle of a store.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, run_a, run_b;
    logic        halted_a, halted_b;
    logic [31:0] ret_a, ret_b;
    logic [3:0]  nf_a, nf_b;

    logic [31:0] rom_a [0:255];
    logic [31:0] rom_b [0:15];

    cpu_sequencer_if #(.PC_W(8)) bus_a ();
    cpu_sequencer_if #(.PC_W(4)) bus_b ();

    assign bus_a.Ins_Data = rom_a[bus_a.Ins_Addr];
    assign bus_a.New_Flag = nf_a;
    assign bus_b.Ins_Data = rom_b[bus_b.Ins_Addr];
    assign bus_b.New_Flag = nf_b;

    cpu_sequencer #(.PC_W(8), .RAM_LAT(1), .CNT_W(32)) dut_a (
        .Clk(clk), .Reset(rst_a), .Run(run_a), .bus(bus_a),
        .Halted(halted_a), .Retired_Count(ret_a)
    );

    cpu_sequencer #(.PC_W(4), .RAM_LAT(3), .CNT_W(32)) dut_b (
        .Clk(clk), .Reset(rst_b), .Run(run_b), .bus(bus_b),
        .Halted(halted_b), .Retired_Count(ret_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-window strobe counts, index 0 = A, 1 = B.
    int n_we  [2];
    int n_mem [2];
    int n_rd  [2];
    int n_ins [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            n_we[i] = 0; n_mem[i] = 0; n_rd[i] = 0; n_ins[i] = 0;
        end
    endtask

    // Advance n cycles, sampling both DUTs on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_we[0]  += int'(bus_a.Reg_WE);
            n_mem[0] += int'(bus_a.Mem_Enable);
            n_rd[0]  += int'(bus_a.Mem_Enable && bus_a.Mem_RW);
            n_ins[0] += int'(bus_a.Ins_Enable);
            n_we[1]  += int'(bus_b.Reg_WE);
            n_mem[1] += int'(bus_b.Mem_Enable);
            n_rd[1]  += int'(bus_b.Mem_Enable && bus_b.Mem_RW);
            n_ins[1] += int'(bus_b.Ins_Enable);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic [3:0] op,
                                        input logic s, input logic [15:0] imm);
        return {cond, op, s, 4'b0000, imm, 3'b000};
    endfunction

    // Program A windows: cycles, Pc after, retired after, Reg_WE pulses, Flag.
    int          a_k   [10] = '{2, 4, 4, 2, 4, 2, 4, 2, 3, 2};
    logic [7:0]  a_pc  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 12, 13};
    int          a_ret [10] = '{0, 1, 2, 2, 3, 3, 4, 4, 5, 5};
    int          a_we  [10] = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 0};
    logic [3:0]  a_flg [10] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};

    // Program B windows.
    int          b_k   [5] = '{9, 9, 5, 6, 9};
    logic [3:0]  b_pc  [5] = '{1, 2, 15, 0, 1};
    int          b_ret [5] = '{1, 2, 3, 4, 5};
    int          b_we  [5] = '{1, 0, 0, 1, 1};
    int          b_mem [5] = '{3, 3, 0, 0, 3};
    int          b_rd  [5] = '{3, 0, 0, 0, 3};
    logic [3:0]  b_flg [5] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hA};

    initial begin
        for (int i = 0; i < 256; i++) rom_a[i] = enc(4'hE, 4'hF, 1'b0, 16'h0);
        for (int i = 0; i < 16; i++)  rom_b[i] = enc(4'hE, 4'hF, 1'b0, 16'h0);
        rom_a[0]  = enc(4'h0, 4'h1, 1'b0, 16'h0);   // EQ, Z=0: skipped
        rom_a[1]  = enc(4'hE, 4'h2, 1'b1, 16'h0);   // AL, S=1: Flag <= 0100
        rom_a[2]  = enc(4'h0, 4'h3, 1'b0, 16'h0);   // EQ, Z=1: executes
        rom_a[3]  = enc(4'hC, 4'h4, 1'b0, 16'h0);   // GT: skipped
        rom_a[4]  = enc(4'hA, 4'h5, 1'b0, 16'h0);   // GE: executes
        rom_a[5]  = enc(4'h2, 4'h6, 1'b0, 16'h0);   // CS: skipped
        rom_a[6]  = enc(4'h9, 4'h7, 1'b0, 16'h0);   // LS: executes
        rom_a[7]  = enc(4'hF, 4'h8, 1'b0, 16'h0);   // NV: skipped
        rom_a[8]  = enc(4'hE, 4'hE, 1'b0, 16'd12);  // B 12
        rom_a[12] = enc(4'h4, 4'h9, 1'b0, 16'h0);   // MI: skipped
        rom_a[13] = enc(4'hE, 4'hF, 1'b0, 16'h0);   // HLT
        rom_b[0]  = enc(4'hE, 4'hC, 1'b1, 16'h0);   // LDR (S ignored)
        rom_b[1]  = enc(4'hE, 4'hD, 1'b0, 16'h0);   // STR
        rom_b[2]  = enc(4'hE, 4'hE, 1'b0, 16'd15);  // B 15
        rom_b[15] = enc(4'hE, 4'h1, 1'b1, 16'h0);   // ALU, S=1: Flag <= 1010

        nf_a = 4'b0100; nf_b = 4'b1010;
        run_a = 1'b0; run_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        step(2);

        chk("rst_pc",     64'(bus_a.Pc), 64'h0);
        chk("rst_instr",  64'(bus_a.Instr), 64'h0);
        chk("rst_flag",   64'(bus_a.Flag), 64'h0);
        chk("rst_ret",    64'(ret_a), 64'h0);
        chk("rst_halt",   64'(halted_a), 64'h0);
        chk("rst_strobe", 64'({bus_a.Ins_Enable, bus_a.Alu_Enable, bus_a.Reg_WE, bus_a.Mem_Enable}), 64'h0);
        chk("rst_memrw",  64'(bus_a.Mem_RW), 64'h1);
        rst_a = 1'b0; rst_b = 1'b0;
        clr();
        step(3);
        chk("idle_no_fetch", 64'(n_ins[0]), 64'h0);

        // ---- A: conditional ALU ops, branch, halt ----
        run_a = 1'b1;
        step(1);
        run_a = 1'b0;
        chk("a_fetch_en", 64'(bus_a.Ins_Enable), 64'h1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) nf_a = 4'hF;   // must not land: no S=1 ALU op follows
            clr();
            step(a_k[i]);
            $display("A win %0d: pc=%0d ret=%0d we=%0d flag=%h", i, bus_a.Pc, ret_a, n_we[0], bus_a.Flag);
            chk($sformatf("a%0d_pc", i),   64'(bus_a.Pc), 64'(a_pc[i]));
            chk($sformatf("a%0d_ret", i),  64'(ret_a), 64'(a_ret[i]));
            chk($sformatf("a%0d_we", i),   64'(n_we[0]), 64'(a_we[i]));
            chk($sformatf("a%0d_flag", i), 64'(bus_a.Flag), 64'(a_flg[i]));
            chk($sformatf("a%0d_mem", i),  64'(n_mem[0]), 64'h0);
        end
        clr();
        step(3);
        $display("A halt: halted=%0d pc=%0d ret=%0d", halted_a, bus_a.Pc, ret_a);
        chk("a_halted",     64'(halted_a), 64'h1);
        chk("a_halt_ret",   64'(ret_a), 64'd6);
        chk("a_halt_pc",    64'(bus_a.Pc), 64'd13);
        chk("a_halt_insen", 64'(bus_a.Ins_Enable), 64'h0);
        run_a = 1'b1;
        clr();
        step(1);
        run_a = 1'b0;
        step(4);
        $display("A run-while-halted: halted=%0d fetches=%0d", halted_a, n_ins[0]);
        chk("a_run_ign_halt",  64'(halted_a), 64'h1);
        chk("a_run_ign_fetch", 64'(n_ins[0]), 64'h0);
        chk("a_run_ign_we",    64'(n_we[0]), 64'h0);
        chk("a_run_ign_ret",   64'(ret_a), 64'd6);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        $display("A reset: pc=%0d flag=%h ret=%0d halted=%0d", bus_a.Pc, bus_a.Flag, ret_a, halted_a);
        chk("a_rst2_pc",    64'(bus_a.Pc), 64'h0);
        chk("a_rst2_flag",  64'(bus_a.Flag), 64'h0);
        chk("a_rst2_ret",   64'(ret_a), 64'h0);
        chk("a_rst2_halt",  64'(halted_a), 64'h0);
        chk("a_rst2_instr", 64'(bus_a.Instr), 64'h0);
        chk("a_rst2_memrw", 64'(bus_a.Mem_RW), 64'h1);

        // ---- B: memory ops at RAM_LAT=3, Pc wrap, reset mid-store ----
        run_b = 1'b1;
        step(1);
        run_b = 1'b0;
        chk("b_fetch_en", 64'(bus_b.Ins_Enable), 64'h1);
        for (int i = 0; i < 5; i++) begin
            clr();
            step(b_k[i]);
            $display("B win %0d: pc=%0d ret=%0d we=%0d mem=%0d rd=%0d flag=%h",
                     i, bus_b.Pc, ret_b, n_we[1], n_mem[1], n_rd[1], bus_b.Flag);
            chk($sformatf("b%0d_pc", i),   64'(bus_b.Pc), 64'(b_pc[i]));
            chk($sformatf("b%0d_ret", i),  64'(ret_b), 64'(b_ret[i]));
            chk($sformatf("b%0d_we", i),   64'(n_we[1]), 64'(b_we[i]));
            chk($sformatf("b%0d_mem", i),  64'(n_mem[1]), 64'(b_mem[i]));
            chk($sformatf("b%0d_rd", i),   64'(n_rd[1]), 64'(b_rd[i]));
            chk($sformatf("b%0d_flag", i), 64'(bus_b.Flag), 64'(b_flg[i]));
        end
        // Now at first FETCH cycle of the STR at address 1; advance into MEM.
        step(5);
        $display("B mid-store: mem_en=%0d mem_rw=%0d", bus_b.Mem_Enable, bus_b.Mem_RW);
        chk("b_str_mem_en", 64'(bus_b.Mem_Enable), 64'h1);
        chk("b_str_mem_rw", 64'(bus_b.Mem_RW), 64'h0);
        rst_b = 1'b1;
        clr();
        step(1);
        rst_b = 1'b0;
        $display("B reset: pc=%0d flag=%h mem_en=%0d we=%0d", bus_b.Pc, bus_b.Flag, bus_b.Mem_Enable, bus_b.Reg_WE);
        chk("b_rst_mem_en", 64'(bus_b.Mem_Enable), 64'h0);
        chk("b_rst_we",     64'(bus_b.Reg_WE), 64'h0);
        chk("b_rst_pc",     64'(bus_b.Pc), 64'h0);
        chk("b_rst_flag",   64'(bus_b.Flag), 64'h0);
        chk("b_rst_ret",    64'(ret_b), 64'h0);
        clr();
        step(4);
        $display("B after reset: we=%0d mem=%0d fetches=%0d", n_we[1], n_mem[1], n_ins[1]);
        chk("b_post_we",    64'(n_we[1]), 64'h0);
        chk("b_post_mem",   64'(n_mem[1]), 64'h0);
        chk("b_post_idle",  64'(n_ins[1]), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle control sequencer for the Master CPU: owns the program counter, instruction register, NZCV flag register and the fetch/decode/execute/memory/writeback state machine. It replaces testbench-driven instruction stepping by driving the instruction RAM, data RAM, register bank write enable and ALU enable itself. It adds conditional execution, branch, halt and a retired-instruction counter.

## Interface
Parameters:
- PC_W, 8: program counter / instruction RAM address width.
- RAM_LAT, 1: read latency in cycles of both RAMs; legal range 1..4.
- CNT_W, 32: retired-instruction counter width.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start pulse; sampled only in IDLE.
- Ins_Enable  out  1  instruction RAM enable.
- Ins_Addr  out  PC_W  instruction RAM address; equals Pc.
- Ins_Data  in  32  instruction RAM read data.
- Instr  out  32  instruction register.
- Pc  out  PC_W  program counter.
- New_Flag  in  4  ALU flag result {N,Z,C,V}.
- Flag  out  4  flag register {N,Z,C,V}, fed to ALU.
- Alu_Enable  out  1  ALU/memory-control enable.
- Reg_WE  out  1  register bank write strobe.
- Mem_Enable  out  1  data RAM enable.
- Mem_RW  out  1  data RAM direction, 1 = read, 0 = write.
- Halted  out  1  core stopped by HLT.
- Retired_Count  out  CNT_W  instructions retired since reset.

## Operation
- Fields of Instr: Cond[31:28], OpCode[27:24], S[23], destination[22:19], source_2[18:15], source_1[14:11], IV_ShftRor[10:6], IV_Mov[18:3].
- Control opcodes: 4'hC LDR, 4'hD STR, 4'hE B (target = IV_Mov[PC_W-1:0]), 4'hF HLT; 4'h0..4'hB are ALU ops.
- Cond (ARM encoding): 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V), E AL, F NV (never).
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- IDLE: Run=1 -> FETCH; otherwise stay.
- FETCH: Ins_Enable=1 for exactly RAM_LAT cycles; Instr <= Ins_Data on the last edge -> DECODE.
- DECODE: evaluate Cond against Flag. Fail -> Pc <= Pc+1, FETCH; failed instructions are not retired and write nothing. Pass -> EXECUTE.
- EXECUTE: Alu_Enable=1. ALU op: Flag <= New_Flag if S=1 -> WB. LDR/STR -> MEM. B: Pc <= target, retire -> FETCH. HLT: retire -> HALT.
- MEM: Alu_Enable=1, Mem_Enable=1 for RAM_LAT cycles; Mem_RW=1 for LDR, 0 for STR -> WB.
- WB: Reg_WE=1 for ALU ops and LDR, 0 for STR; Alu_Enable=1; Pc <= Pc+1; retire -> FETCH.
- Pc increment wraps from 2^PC_W-1 to 0. Retired_Count wraps at 2^CNT_W.
- S is ignored for LDR/STR/B/HLT; Flag changes only in EXECUTE of a passed ALU op.
- HALT: Halted=1 and all strobes 0; exit only via Reset. Run is ignored outside IDLE.

## Timing
- Reset values: state IDLE, Pc 0, Instr 0, Flag 4'b0000, Retired_Count 0. Ins_Enable, Alu_Enable, Reg_WE, Mem_Enable and Halted are 0. Mem_RW is 1.
- Reset asserted in any state wins over every transition. No Reg_WE or Mem_Enable is asserted in the cycle after the Reset edge. An in-flight instruction is discarded.
- Cycles per instruction, Run edge to next FETCH: ALU RAM_LAT+3; LDR/STR 2·RAM_LAT+3; B RAM_LAT+2; cond-fail RAM_LAT+1; HLT RAM_LAT+2 to Halted=1.
- All outputs are registered or decoded from state only; there is no combinational path from New_Flag or Ins_Data to outputs.

## Structure
- Shared package cpu_pkg: opcode constants (OP_LDR, OP_STR, OP_B, OP_HLT), condition codes, flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0), state encoding.
- One combinational sub-module, cond_check (Cond, Flag -> pass), reused later by the ALU.
- The latency counter is a small local counter reused by FETCH and MEM.

## Test plan
- RAM_LAT=1; ALU op with Cond=E, S=1; New_Flag=4'b0100 -> Reg_WE pulses 4 cycles after Run, Flag=0100, Pc=1, Retired_Count=1.
- Cond=0 (EQ) with Flag Z=0 -> no Reg_WE/Mem_Enable, Pc+1 after 2 cycles, Retired_Count unchanged; same with Z=1 executes.
- RAM_LAT=3; LDR then STR -> Mem_Enable high 3 cycles each, Mem_RW 1 then 0, Reg_WE only for LDR, 9 cycles each.
- PC_W=4, B to 4'hF, ALU op at 0xF -> Pc wraps to 0 after WB.
- HLT at address 2 -> Halted=1, Retired_Count=3, Run pulses ignored; Reset -> all reset values.
- Reset asserted during MEM of STR -> no write strobe afterwards, state IDLE, Pc=0, Flag=0.
